// File: rtl/card_datapath.sv
// card_datapath: card generator, six write-once card registers and two mod-10 scorers; CARD_OVERRIDE_EN adds card_in.
// Cards, cards_dealt and illegal_load register on the strobe edge; scores are combinational; no handshake or backpressure.
module card_datapath (
   input  logic       slow_clock,
   input  logic       reset,
`ifdef CARD_OVERRIDE_EN
   input  logic [3:0] card_in,
`endif
   input  logic       load_pcard1,
   input  logic       load_pcard2,
   input  logic       load_pcard3,
   input  logic       load_dcard1,
   input  logic       load_dcard2,
   input  logic       load_dcard3,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] dcard1,
   output logic [3:0] dcard2,
   output logic [3:0] dcard3,
   output logic [3:0] pscore,
   output logic [3:0] dscore,
   output logic [2:0] cards_dealt,
   output logic       illegal_load
);

   logic [3:0] new_card;
   logic [3:0] cap_card;
   logic [5:0] load;
   logic [5:0] filled;
   logic [3:0] card_q [6];
   logic       multi;
   logic       any_load;
   logic       target_full;
   logic       capture;

   function automatic logic [3:0] card_value(input logic [3:0] code);
      return (code <= 4'd9) ? code : 4'd0;
   endfunction

   // Sum is at most 27, so two compare-subtract stages cover the whole range.
   function automatic logic [3:0] mod10(input logic [4:0] sum);
      logic [4:0] r;
      if (sum >= 5'd20)      r = sum - 5'd20;
      else if (sum >= 5'd10) r = sum - 5'd10;
      else                   r = sum;
      return r[3:0];
   endfunction

   assign load = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

   always_comb begin
      filled = '0;
      for (int i = 0; i < 6; i++)
         filled[i] = (card_q[i] != 4'd0);
   end

   assign multi       = |(load & (load - 6'd1));
   assign any_load    = |load;
   assign target_full = |(load & filled);
   assign capture     = any_load && !multi && !target_full;

`ifdef CARD_OVERRIDE_EN
   assign cap_card = (card_in >= 4'd1 && card_in <= 4'd13) ? card_in : new_card;
`else
   assign cap_card = new_card;
`endif

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         new_card     <= 4'd1;
         cards_dealt  <= 3'd0;
         illegal_load <= 1'b0;
         for (int i = 0; i < 6; i++)
            card_q[i] <= 4'd0;
      end else begin
         new_card <= (new_card == 4'd13) ? 4'd1 : new_card + 4'd1;
         if (capture) begin
            for (int i = 0; i < 6; i++)
               if (load[i])
                  card_q[i] <= cap_card;
            if (cards_dealt != 3'd6)
               cards_dealt <= cards_dealt + 3'd1;
         end
         if (any_load && (multi || target_full))
            illegal_load <= 1'b1;
      end
   end

   assign pcard1 = card_q[0];
   assign pcard2 = card_q[1];
   assign pcard3 = card_q[2];
   assign dcard1 = card_q[3];
   assign dcard2 = card_q[4];
   assign dcard3 = card_q[5];

   assign pscore = mod10({1'b0, card_value(card_q[0])} + {1'b0, card_value(card_q[1])}
                         + {1'b0, card_value(card_q[2])});
   assign dscore = mod10({1'b0, card_value(card_q[3])} + {1'b0, card_value(card_q[4])}
                         + {1'b0, card_value(card_q[5])});

endmodule

// File: tb/tb_card_datapath.sv
// Randomized and directed bench for card_datapath against a deal-level reference model.
module tb_card_datapath;

   logic       slow_clock;
   logic       reset;
   logic [3:0] card_in;
   logic [5:0] load;
   logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
   logic [3:0] pscore, dscore;
   logic [2:0] cards_dealt;
   logic       illegal_load;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_k;
   int m_card [6];
   int m_dealt;
   int m_ill;

   card_datapath dut (
      .slow_clock  (slow_clock),
      .reset       (reset),
`ifdef CARD_OVERRIDE_EN
      .card_in     (card_in),
`endif
      .load_pcard1 (load[0]),
      .load_pcard2 (load[1]),
      .load_pcard3 (load[2]),
      .load_dcard1 (load[3]),
      .load_dcard2 (load[4]),
      .load_dcard3 (load[5]),
      .pcard1      (pcard1),
      .pcard2      (pcard2),
      .pcard3      (pcard3),
      .dcard1      (dcard1),
      .dcard2      (dcard2),
      .dcard3      (dcard3),
      .pscore      (pscore),
      .dscore      (dscore),
      .cards_dealt (cards_dealt),
      .illegal_load(illegal_load)
   );

   initial begin
      slow_clock = 1'b0;
      forever #5 slow_clock = ~slow_clock;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int val(input int c);
      return (c >= 1 && c <= 9) ? c : 0;
   endfunction

   function automatic int exp_score(input int a, input int b, input int c);
      return (val(a) + val(b) + val(c)) % 10;
   endfunction

   // The k-th edge after release offers card (k mod 13)+1 unless card_in overrides it.
   always @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         m_k = 0;
         m_dealt = 0;
         m_ill = 0;
         for (int i = 0; i < 6; i++) m_card[i] = 0;
      end else begin
         int offer;
         int n;
         int idx;
         offer = (m_k % 13) + 1;
`ifdef CARD_OVERRIDE_EN
         if (card_in >= 1 && card_in <= 13) offer = int'(card_in);
`endif
         n = $countones(load);
         idx = 0;
         for (int i = 0; i < 6; i++) if (load[i]) idx = i;
         if (n > 1) m_ill = 1;
         else if (n == 1) begin
            if (m_card[idx] != 0) m_ill = 1;
            else begin
               m_card[idx] = offer;
               if (m_dealt < 6) m_dealt++;
            end
         end
         m_k++;
      end
   end

   always @(negedge slow_clock) begin
      chk("pcard1", int'(pcard1), m_card[0]);
      chk("pcard2", int'(pcard2), m_card[1]);
      chk("pcard3", int'(pcard3), m_card[2]);
      chk("dcard1", int'(dcard1), m_card[3]);
      chk("dcard2", int'(dcard2), m_card[4]);
      chk("dcard3", int'(dcard3), m_card[5]);
      chk("pscore", int'(pscore), exp_score(m_card[0], m_card[1], m_card[2]));
      chk("dscore", int'(dscore), exp_score(m_card[3], m_card[4], m_card[5]));
      chk("cards_dealt", int'(cards_dealt), m_dealt);
      chk("illegal_load", int'(illegal_load), m_ill);
   end

   // Called at posedge+2; releases reset before the next edge, which becomes edge 0.
   task automatic do_reset();
      load = '0;
      reset = 1'b1;
      #4;
      reset = 1'b0;
   endtask

   task automatic tick(input logic [5:0] l);
      load = l;
      @(posedge slow_clock);
      #2;
      load = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(6'b000000);
   endtask

   localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
   localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

   initial begin
      reset = 1'b1;
      load = '0;
      card_in = 4'd0;
      @(posedge slow_clock);
      #2;
      do_reset();
      chk("reset pcard1", int'(pcard1), 0);
      chk("reset dscore", int'(dscore), 0);
      chk("reset cards_dealt", int'(cards_dealt), 0);
      chk("reset illegal", int'(illegal_load), 0);

      // Basic deal
      tick(P1); tick(D1); tick(P2); tick(D2);
      chk("basic pcard1", int'(pcard1), 1);
      chk("basic dcard1", int'(dcard1), 2);
      chk("basic pcard2", int'(pcard2), 3);
      chk("basic dcard2", int'(dcard2), 4);
      chk("basic pscore", int'(pscore), 4);
      chk("basic dscore", int'(dscore), 6);
      chk("basic dealt", int'(cards_dealt), 4);
      chk("basic illegal", int'(illegal_load), 0);

      // Face cards and generator wrap
      do_reset();
      idle(9);
      tick(P1); idle(2); tick(P2); tick(P3);
      chk("face pcard1", int'(pcard1), 10);
      chk("face pcard2", int'(pcard2), 13);
      chk("face pcard3", int'(pcard3), 1);
      chk("face pscore", int'(pscore), 1);

      // Mod-10 scoring
      do_reset();
      idle(8);
      tick(D1); tick(D2);
      chk("mod dcard1", int'(dcard1), 9);
      chk("mod dcard2", int'(dcard2), 10);
      chk("mod dscore 9", int'(dscore), 9);
      idle(10);
      tick(D3);
      chk("mod dcard3", int'(dcard3), 8);
      chk("mod dscore 7", int'(dscore), 7);

      // Reload of a filled register
      do_reset();
      tick(P1); idle(1); tick(P1);
      chk("reload pcard1", int'(pcard1), 1);
      chk("reload illegal", int'(illegal_load), 1);
      chk("reload dealt", int'(cards_dealt), 1);

      // Two strobes on one edge
      do_reset();
      tick(P1 | D1);
      chk("multi pcard1", int'(pcard1), 0);
      chk("multi dcard1", int'(dcard1), 0);
      chk("multi illegal", int'(illegal_load), 1);
      chk("multi dealt", int'(cards_dealt), 0);

      // Asynchronous reset mid-round
      do_reset();
      idle(4);
      tick(P1); tick(P2); tick(D1);
      chk("mid pre dealt", int'(cards_dealt), 3);
      reset = 1'b1;
      #1;
      chk("mid async pcard1", int'(pcard1), 0);
      chk("mid async dcard1", int'(dcard1), 0);
      chk("mid async pscore", int'(pscore), 0);
      chk("mid async dealt", int'(cards_dealt), 0);
      #2;
      reset = 1'b0;
      tick(P1);
      chk("mid restart pcard1", int'(pcard1), 1);

`ifdef CARD_OVERRIDE_EN
      do_reset();
      card_in = 4'd12;
      tick(P3);
      chk("ovr pcard3", int'(pcard3), 12);
      chk("ovr pscore", int'(pscore), 0);
      card_in = 4'd15;
      tick(P1);
      chk("ovr fallback pcard1", int'(pcard1), 2);
      card_in = 4'd0;
`endif

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         do_reset();
         for (int i = 0; i < 30; i++) begin
            int sel;
            logic [5:0] l;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) l = 6'b000000;
            else if (sel < 9) l = 6'b000001 << $urandom_range(0, 5);
            else l = 6'($urandom);
`ifdef CARD_OVERRIDE_EN
            card_in = 4'($urandom_range(0, 15));
`endif
            tick(l);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
